level_sequence_checker: RTL

- Upstream stage of the game controller. Generates the digit sequence for the current level, displays it digit by digit, then checks player submissions.
- Produces the correct, incorrect and passed pulses that the game controller consumes.
- Takes currentlevel and the sequence/submit button pulses (seq_b_out, psub_b_out) from the game controller.

---
 rtl/level_sequence_checker_pkg.sv | 22 ++
 rtl/level_sequence_checker_lfsr.sv | 29 ++
 rtl/level_sequence_checker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/level_sequence_checker_pkg.sv
// Shared definitions for the level sequence checker: FSM state encoding,
// the blank display code and the LFSR feedback taps.
package level_sequence_checker_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        SHOW    = 3'd2,
        GAP     = 3'd3,
        WAIT_IN = 3'd4
    } state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // x^16 + x^14 + x^13 + x^11 + 1, as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    function automatic logic [3:0] digit_mod10(input logic [3:0] v);
        return (v >= 4'd10) ? (v - 4'd10) : v;
    endfunction

endpackage

// File: rtl/level_sequence_checker_lfsr.sv
// Free-running 16-bit Fibonacci LFSR with a 0..9 digit derived from its low nibble.
module seq_lfsr
    import level_sequence_checker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] digit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAP_MASK)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign digit_o = digit_mod10(lfsr_q[3:0]);

endmodule

// File: rtl/level_sequence_checker.sv
// Generates a pseudo-random digit sequence per round, shows it one digit at a
// time, then checks the player's submissions and emits correct/incorrect/passed.
module level_sequence_checker
    import level_sequence_checker_pkg::*;
#(
    parameter int          SHOW_CYCLES = 25000000,
    parameter int          GAP_CYCLES  = 5000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MAX_LEN     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] currentlevel,
    input  logic       seq_b,
    input  logic       psub_b,
    input  logic [3:0] player_digit,
    output logic       correct,
    output logic       incorrect,
    output logic       passed,
    output logic [3:0] display_digit,
    output logic       display_valid,
    output logic       awaiting_input,
    output logic [3:0] entry_index
);

    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [4:0]    MAX_LEN5  = 5'(MAX_LEN);

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          correct_q, correct_d;
    logic          incorrect_q, incorrect_d;
    logic          passed_q, passed_d;

    logic [3:0]    seq_mem [MAX_LEN];
    logic [AW-1:0] addr;
    logic [3:0]    gen_digit;
    logic          mem_we;
    logic [4:0]    lvl_len;
    logic [4:0]    new_len;
    logic          at_last;

    seq_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst),
        .digit_o (gen_digit)
    );

    // Five-bit arithmetic keeps a 16-digit round from wrapping to zero.
    assign lvl_len = {1'b0, currentlevel} + 5'd1;
    assign new_len = (lvl_len > MAX_LEN5) ? MAX_LEN5 : lvl_len;
    assign at_last = (idx_q == (len_q - 5'd1));
    assign addr    = idx_q[AW-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        timer_d     = timer_q;
        correct_d   = 1'b0;
        incorrect_d = 1'b0;
        passed_d    = 1'b0;
        mem_we      = 1'b0;

        // A new round request overrides everything, including a same-cycle submit.
        if (seq_b) begin
            state_d = GEN;
            len_d   = new_len;
            idx_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                GEN: begin
                    mem_we = 1'b1;
                    if (at_last) begin
                        idx_d   = 5'd0;
                        timer_d = SHOW_LOAD;
                        state_d = SHOW;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                SHOW: begin
                    if (timer_q == '0) begin
                        timer_d = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) begin
                        if (at_last) begin
                            idx_d   = 5'd0;
                            state_d = WAIT_IN;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            timer_d = SHOW_LOAD;
                            state_d = SHOW;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                WAIT_IN: begin
                    if (psub_b) begin
                        if ((player_digit > 4'd9) || (player_digit != seq_mem[addr])) begin
                            incorrect_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            correct_d = 1'b1;
                            if (at_last) begin
                                passed_d = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            len_q       <= 5'd1;
            timer_q     <= '0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            passed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            timer_q     <= timer_d;
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            passed_q    <= passed_d;
        end
    end

    // Contents are meaningless until GEN has filled them, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            seq_mem[addr] <= gen_digit;
        end
    end

    assign correct        = correct_q;
    assign incorrect      = incorrect_q;
    assign passed         = passed_q;
    assign display_valid  = (state_q == SHOW);
    assign display_digit  = (state_q == SHOW) ? seq_mem[addr] : BLANK_DIGIT;
    assign awaiting_input = (state_q == WAIT_IN);
    assign entry_index    = (state_q == WAIT_IN) ? idx_q[3:0] : 4'd0;

endmodule
